// File: rtl/final_soc_pkg.sv
// ============================================================================
// Module      : final_soc_pkg
// Description : Register addresses and debounce state encoding shared by the
//               accumulate-button controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package final_soc_pkg;

    localparam logic [1:0] ADDR_LEVEL   = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage : final_soc_pkg

`default_nettype wire

// File: rtl/final_soc_debounce.sv
// ============================================================================
// Module      : final_soc_debounce
// Description : Two-flop synchroniser plus debounce FSM; emits the debounced
//               level and a single-cycle pulse on each committed press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module final_soc_debounce
    import final_soc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_port,
    output logic level,
    output logic press_pulse
);

    localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    // Pin level that means "not pressed", so reset never looks like a press
    localparam logic             c_released = ACTIVE_LOW;

    logic               r_sync1;
    logic               r_sync2;
    deb_state_t         r_state;
    deb_state_t         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_pressed_raw;

    assign w_pressed_raw = r_sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= c_released;
            r_sync2 <= c_released;
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        press_pulse  = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_pressed_raw) begin
                    w_cnt_next   = c_cnt_one;
                    w_state_next = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_pressed_raw) begin
                    w_state_next = ST_RELEASED;
                end else if (r_cnt == c_cnt_last) begin
                    press_pulse  = 1'b1;
                    w_state_next = ST_PRESSED;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_PRESSED: begin
                if (!w_pressed_raw) begin
                    w_cnt_next   = c_cnt_one;
                    w_state_next = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_pressed_raw) begin
                    w_state_next = ST_PRESSED;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = ST_RELEASED;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            default: w_state_next = ST_RELEASED;
        endcase
    end

    assign level = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

endmodule : final_soc_debounce

`default_nettype wire

// File: rtl/final_soc_accumulate_ctrl.sv
// ============================================================================
// Module      : final_soc_accumulate_ctrl
// Description : Avalon-MM slave exposing the debounced accumulate button as
//               level, saturating press count, edge flag and maskable irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module final_soc_accumulate_ctrl
    import final_soc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 8,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_port,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_level;
    logic             w_press;
    logic [CNT_W-1:0] r_press_count;
    logic             r_edge_capture;
    logic             r_irq_mask;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_wr_count;
    logic             w_wr_mask;
    logic             w_wr_edge_clr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    final_soc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .in_port     (in_port),
        .level       (w_level),
        .press_pulse (w_press)
    );

    assign w_wr_count     = write && (address == ADDR_COUNT);
    assign w_wr_mask      = write && (address == ADDR_IRQMASK);
    assign w_wr_edge_clr  = write && (address == ADDR_EDGE) && writedata[0];
    assign w_count_inc    = (r_press_count == c_cnt_max) ? r_press_count
                                                         : r_press_count + c_cnt_one;
    assign w_unused_wdata = ^writedata[31:1];

    // A commit always wins over a concurrent clear: count restarts at 1, flag stays set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press_count  <= '0;
            r_edge_capture <= 1'b0;
            r_irq_mask     <= 1'b0;
            irq            <= 1'b0;
        end else begin
            if (w_press) begin
                r_press_count <= w_wr_count ? c_cnt_one : w_count_inc;
            end else if (w_wr_count) begin
                r_press_count <= '0;
            end

            if (w_press) begin
                r_edge_capture <= 1'b1;
            end else if (w_wr_edge_clr) begin
                r_edge_capture <= 1'b0;
            end

            if (w_wr_mask) begin
                r_irq_mask <= writedata[0];
            end

            irq <= r_edge_capture & r_irq_mask;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_LEVEL:   w_rdata[0] = w_level;
            ADDR_COUNT:   w_rdata    = 32'(r_press_count);
            ADDR_IRQMASK: w_rdata[0] = r_irq_mask;
            ADDR_EDGE:    w_rdata[0] = r_edge_capture;
            default:      w_rdata    = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= w_rdata;
        end
    end

endmodule : final_soc_accumulate_ctrl

`default_nettype wire

// File: tb/tb_final_soc_accumulate_ctrl.sv
// ============================================================================
// Module      : tb_final_soc_accumulate_ctrl
// Description : Directed self-checking bench for the accumulate-button
//               controller (DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1, CNT_W = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_final_soc_accumulate_ctrl;

    localparam logic [1:0] A_LEVEL = 2'd0;
    localparam logic [1:0] A_COUNT = 2'd1;
    localparam logic [1:0] A_MASK  = 2'd2;
    localparam logic [1:0] A_EDGE  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_port;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] rd;

    final_soc_accumulate_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Every tick leaves the bench 1 time unit after a rising edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic do_press();
        in_port = 1'b0;
        tick(8);
        in_port = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_total++;
        if (readdata !== 32'd0) $display("FAIL reset_readdata: got %0h expected 0", readdata);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq);
        else n_pass++;
        reset = 1'b0;
        tick(2);
        bus_read(A_LEVEL, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL reset_level: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL reset_count: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_MASK, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL reset_mask: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL reset_edge: got %0h expected 0", rd);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        in_port = 1'b0;
        tick(5);
        bus_read(A_COUNT, rd);     // sampled on edge 6, before the commit lands
        n_total++;
        if (rd !== 32'd0) $display("FAIL press_count_edge6: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL press_count: got %0h expected 1", rd);
        else n_pass++;
        bus_read(A_LEVEL, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL press_level: got %0h expected 1", rd);
        else n_pass++;
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL press_edge: got %0h expected 1", rd);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL press_irq_masked: got %0b expected 0", irq);
        else n_pass++;
        bus_write(A_LEVEL, 32'd0);
        bus_read(A_LEVEL, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL level_readonly: got %0h expected 1", rd);
        else n_pass++;
        tick(4);
        n_total++;
        if (readdata !== 32'd1) $display("FAIL readdata_hold: got %0h expected 1", readdata);
        else n_pass++;
        in_port = 1'b1;
        tick(8);
        bus_read(A_LEVEL, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL release_level: got %0h expected 0", rd);
        else n_pass++;
        bus_write(A_EDGE, 32'd1);
        bus_write(A_COUNT, 32'd0);
    endtask

    task automatic test_bounce();
        address = A_LEVEL;
        read    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_port = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int j = 0; j < 2; j++) begin
                tick();
                n_total++;
                if (readdata !== 32'd0) $display("FAIL bounce_level[%0d]: got %0h expected 0", 2 * i + j, readdata);
                else n_pass++;
            end
        end
        read    = 1'b0;
        in_port = 1'b1;
        tick(8);
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL bounce_count: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL bounce_edge: got %0h expected 0", rd);
        else n_pass++;
    endtask

    task automatic test_irq_flow();
        bus_write(A_MASK, 32'd1);
        in_port = 1'b0;
        tick(6);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_at_commit: got %0b expected 0", irq);
        else n_pass++;
        tick();
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_rise: got %0b expected 1", irq);
        else n_pass++;
        bus_write(A_EDGE, 32'd0);
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL edge_w0_noeffect: got %0h expected 1", rd);
        else n_pass++;
        bus_write(A_EDGE, 32'd1);
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_same_edge_as_clear: got %0b expected 1", irq);
        else n_pass++;
        tick();
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_after_clear: got %0b expected 0", irq);
        else n_pass++;
        in_port = 1'b1;
        tick(8);
        bus_write(A_MASK, 32'd0);
        bus_write(A_COUNT, 32'd0);
    endtask

    task automatic test_collisions();
        do_press();                // count = 1, edge = 1
        address = A_COUNT;
        read    = 1'b1;
        bus_write(A_COUNT, 32'd0); // read and write together
        n_total++;
        if (readdata !== 32'd1) $display("FAIL rw_pre_write_value: got %0h expected 1", readdata);
        else n_pass++;
        read = 1'b0;
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rw_write_applied: got %0h expected 0", rd);
        else n_pass++;
        do_press();                // count = 1 again
        in_port = 1'b0;
        tick(5);
        bus_write(A_COUNT, 32'd0); // lands on the commit edge
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL collide_count: got %0h expected 1", rd);
        else n_pass++;
        in_port = 1'b1;
        tick(8);
        bus_write(A_EDGE, 32'd1);
        in_port = 1'b0;
        tick(5);
        bus_write(A_EDGE, 32'd1);  // lands on the commit edge
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL collide_edge: got %0h expected 1", rd);
        else n_pass++;
        in_port = 1'b1;
        tick(8);
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) do_press();
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd255) $display("FAIL count_255: got %0h expected ff", rd);
        else n_pass++;
        do_press();
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd255) $display("FAIL count_saturate: got %0h expected ff", rd);
        else n_pass++;
        bus_write(A_COUNT, 32'd7);
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL count_clear: got %0h expected 0", rd);
        else n_pass++;
        do_press();
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL count_after_clear: got %0h expected 1", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus_write(A_MASK, 32'd1);
        tick(2);                   // edge=1 & mask=1 -> irq high
        in_port = 1'b0;
        tick(5);                   // third cycle of PRESS_WAIT
        reset = 1'b1;
        #1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL midreset_irq: got %0b expected 0", irq);
        else n_pass++;
        n_total++;
        if (readdata !== 32'd0) $display("FAIL midreset_readdata: got %0h expected 0", readdata);
        else n_pass++;
        tick(2);
        reset = 1'b0;
        bus_read(A_MASK, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL midreset_mask: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_EDGE, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL midreset_edge: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_LEVEL, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL midreset_level: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL midreset_count: got %0h expected 0", rd);
        else n_pass++;
        tick();
        bus_read(A_COUNT, rd);     // sampled on the commit edge: pre-commit value
        n_total++;
        if (rd !== 32'd0) $display("FAIL recommit_early: got %0h expected 0", rd);
        else n_pass++;
        bus_read(A_COUNT, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL recommit_count: got %0h expected 1", rd);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL recommit_irq: got %0b expected 0", irq);
        else n_pass++;
        in_port = 1'b1;
        tick(8);
    endtask

    initial begin
        reset     = 1'b1;
        in_port   = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_irq_flow();
        test_collisions();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_final_soc_accumulate_ctrl

`default_nettype wire

// File: doc/final_soc_accumulate_ctrl.md
# final_soc_accumulate_ctrl

Debounce, press-capture and interrupt controller for the single "accumulate" pushbutton of the quiz SoC. It is an Avalon-MM slave on the system interconnect. It synchronises and debounces the raw button and counts committed presses. Software sees a debounced level, a press counter, an edge-capture flag and a maskable interrupt, so it no longer polls a raw level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable sampled cycles required to commit a level change (10 ms at 50 MHz); legal range ≥2.
- CNT_W, 8, press-counter width; legal range 1..32.
- ACTIVE_LOW, 1, 1 = button pressed when in_port is 0 (board KEY convention).

Ports (single clock domain; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_port  in  1  raw, asynchronous button pin.
- address  in  2  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, registered.

## Operation
- in_port passes through a 2-flop synchroniser. The second flop output is XORed with ACTIVE_LOW to give `pressed_raw`.
- Debounce FSM states:
  - RELEASED: if pressed_raw = 1, load counter = 1 and go to PRESS_WAIT.
  - PRESS_WAIT: if pressed_raw = 0, go to RELEASED; else if counter = DEBOUNCE_CYCLES−1, commit a press and go to PRESSED; else increment the counter.
  - PRESSED: if pressed_raw = 0, load counter = 1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: if pressed_raw = 1, go to PRESSED; else if counter = DEBOUNCE_CYCLES−1, go to RELEASED; else increment the counter.
- Debounced level = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Press commit, for one cycle only:
  - edge_capture is set to 1.
  - press_count increments. It saturates at 2^CNT_W−1 and does not wrap.
- Register map (readdata bits above the defined fields read 0):
  - Address 0, LEVEL, RO: bit0 = debounced level. Writes are ignored.
  - Address 1, COUNT, R/W: reads press_count. Any write clears it to 0.
  - Address 2, IRQMASK, R/W: bit0 = irq_mask.
  - Address 3, EDGE, R/W1C: bit0 = edge_capture. Writing 1 to bit0 clears it; writing 0 has no effect.
- irq register is loaded each cycle with edge_capture & irq_mask, using the register values at the clock edge.
- Simultaneous events:
  - Commit in the same cycle as an EDGE W1C: edge_capture ends at 1 (set wins).
  - Commit in the same cycle as a COUNT write: press_count ends at 1.
  - read and write asserted together: the write takes effect, and readdata returns pre-write values.

## Timing
- Reset values:
  - readdata = 0, irq = 0.
  - Synchroniser flops hold the released pin level, so no spurious press is seen.
  - FSM = RELEASED, counter = 0.
  - edge_capture = 0, press_count = 0, irq_mask = 0.
- Reset asserted mid-debounce or mid-press aborts immediately. After release the block waits in RELEASED. A button still held is then re-debounced and committed as a new press.
- Read latency is 1 cycle: readdata is valid on the clock edge after read is sampled. No waitrequest. readdata holds its value between reads.
- Writes take effect at the edge that samples write.
- Press latency from an in_port transition: 2 cycles (synchroniser) + DEBOUNCE_CYCLES cycles to the commit edge. edge_capture and the COUNT change are visible on that edge; irq rises one cycle later.
- Any bounce shorter than DEBOUNCE_CYCLES returns the FSM to its previous stable state with no commit.

## Structure
- Shared package final_soc_pkg holds:
  - register address constants ADDR_LEVEL = 0, ADDR_COUNT = 1, ADDR_IRQMASK = 2, ADDR_EDGE = 3;
  - the 2-bit debounce state enum.
- Sub-module final_soc_debounce contains the synchroniser, debounce FSM and counter.
  - Parameters: DEBOUNCE_CYCLES, ACTIVE_LOW.
  - Outputs: `level` and a one-cycle `press_pulse`.
  - The top level holds the register file, irq and read mux.
- Counter width is $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1, CNT_W = 8.
- Clean press: in_port 1→0 held for 10 cycles → LEVEL = 1 and COUNT = 1 at cycle 6 after the transition; EDGE = 1; irq stays 0 while the mask is 0.
- Bounce rejection: in_port toggles 0/1 every 2 cycles for 20 cycles, then settles at 1 → COUNT = 0, EDGE = 0, LEVEL = 0 throughout.
- Interrupt flow:
  - Write IRQMASK = 1, then perform a clean press → irq = 1 one cycle after the commit.
  - Write EDGE = 1 → irq = 0 on the following cycle.
  - Write EDGE = 0 on a set flag → edge_capture stays 1.
- Collisions: force the commit on the same cycle as an EDGE W1C and a COUNT write → edge_capture = 1 and COUNT = 1 afterwards.
- Saturation: 256 clean presses from reset → COUNT reads 255. A COUNT write then gives 0, and one further press gives 1.
- Reset mid-debounce: assert reset at cycle 3 of PRESS_WAIT with the button held, then release reset → all registers 0, readdata = 0, irq = 0. The held button commits COUNT = 1 after 2 + 4 cycles.
